// File: rtl/aes_key_schedule.sv
// AES-128 key schedule controller: expands one round key per accepted transfer,
// streams each key over valid/ready and keeps all eleven in a registered-read bank.
module aes_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  output logic [3:0]   key_idx,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    sub_byte = SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // One KeyExpansion round: word 0 absorbs SubWord(RotWord(w3)) ^ Rcon, the rest chain.
  function automatic logic [127:0] expand_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sub_byte(w3[23:16]), sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])}
         ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    expand_round = {n0, n1, n2, n3};
  endfunction

  state_t         state, state_d;
  logic [7:0]     rcon;
  logic [127:0]   next_key;
  logic [127:0]   bank [0:NR];
  logic           load, advance, finish;

  assign next_key = expand_round(key_out, rcon);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = RUN;
      RUN:  if (key_valid && key_ready && key_idx == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE: load = start;
      RUN: begin
        busy    = 1'b1;
        advance = key_valid && key_ready && (key_idx != LAST);
        finish  = key_valid && key_ready && (key_idx == LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out    <= '0;
      key_idx    <= '0;
      key_valid  <= 1'b0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      rcon       <= 8'h01;
    end else begin
      done <= finish;
      if (load) begin
        key_out    <= key_in;
        key_idx    <= '0;
        key_valid  <= 1'b1;
        rcon       <= 8'h01;
        keys_ready <= 1'b0;
      end else if (advance) begin
        key_out <= next_key;
        key_idx <= key_idx + 4'd1;
        rcon    <= xtime(rcon);
      end else if (finish) begin
        key_valid  <= 1'b0;
        keys_ready <= 1'b1;
      end
    end
  end

  // Bank writes track the stream; reads see the pre-write contents of a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) bank[i] <= '0;
    end else if (load) begin
      bank[0] <= key_in;
    end else if (advance) begin
      bank[key_idx + 4'd1] <= next_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_key <= '0;
    else        rd_key <= (rd_idx <= LAST) ? bank[rd_idx] : '0;
  end

endmodule
